dec_8b10b: RTL
==============

# dec_8b10b

Receive-side 8b/10b decoder for the JESD204B link layer. It is the inverse of the transmit RD-minus/RD-plus encoding ROMs. The block takes one 10-bit code group per valid cycle (bit order abcdeifghj) and returns the decoded byte (bit order HGFEDCBA) with a control-character flag. It tracks the receiver running disparity and flags code-group violations and disparity violations, feeding the lane's code-group-sync and ILAS logic downstream.

## Interface
- INIT_RD, 1'b0, running disparity loaded at reset and on clear (0 = RD-, 1 = RD+)
- clk  in  1  core clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- i_data  in  10  code group, abcdeifghj, a = bit 9
- i_valid  in  1  i_data qualifies this cycle
- i_rd_clr  in  1  synchronous force of running disparity to INIT_RD
- o_data  out  8  decoded byte HGFEDCBA, H = bit 7
- o_k  out  1  1 = control character K, 0 = data D
- o_valid  out  1  outputs qualify this cycle
- o_code_err  out  1  code group not in the 8b/10b table
- o_disp_err  out  1  code group valid but wrong for current running disparity
- o_rd  out  1  running disparity after the last decoded group (0 = RD-)

## Operation
- Stage 1 registers i_data and i_valid. It classifies the 6b sub-block (abcdei) and the 4b sub-block (fghj) by ones count:
  - 6b: 2, 3 or 4 ones is legal; anything else is illegal.
  - 4b: 1, 2 or 3 ones is legal.
  - Also illegal: 6b 000000/111111/111100/000011 forms not in the table, and 4b 0000/1111.
- Stage 2 decodes and updates disparity on valid words only.
  - 5b lookup: abcdei → EDCBA. 3b lookup: fghj → HGF.
  - K detection:
    - 6b 001111 or 110000 → K28.y, any of the eight 4b codes.
    - 6b of D23/D27/D29/D30 with 4b 1000 (RD-) or 0111 (RD+) → K23.7/K27.7/K29.7/K30.7.
    - All twelve K codes are accepted. Any other K-class combination sets o_code_err.
  - D.x.A7 (4b 0111/1000) is accepted only after 6b x = 17, 18, 20 (RD-) or 11, 13, 14 (RD+). Any other use sets o_code_err.
- Disparity check, applied per sub-block against the running disparity entering that sub-block:
  - 4-ones 6b (3-ones 4b) entering RD+ → error.
  - 2-ones 6b (1-ones 4b) entering RD- → error.
  - 000111 or 0011 entering RD- → error.
  - 111000 or 1100 entering RD+ → error.
- RD after a sub-block:
  - + if more ones, or if the sub-block is 000111/0011.
  - - if more zeros, or if the sub-block is 111000/1100.
  - Otherwise unchanged.
  - The update applies even on a disparity error, so the receiver resynchronises to the line.
- On o_code_err:
  - o_data = 0, o_k = 0, o_disp_err = 0.
  - RD follows the sub-block rule for any legal sub-block; an illegal sub-block leaves RD unchanged.
- i_rd_clr: RD becomes INIT_RD at the next edge. If a valid word is in stage 2 the same cycle, it is checked against the old RD, and its update is discarded in favour of the clear.

## Timing
- Reset values: o_data = 0, o_k = 0, o_valid = 0, o_code_err = 0, o_disp_err = 0, o_rd = INIT_RD, pipeline valids = 0.
- Latency: i_valid at edge N → o_valid at edge N+2. Full throughput, one group per cycle, no backpressure.
- Bubbles (i_valid = 0) propagate as o_valid = 0:
  - o_data, o_k and the error flags hold their last values.
  - RD holds.
- Error flags are qualified by o_valid and are single-cycle per word; they are not sticky.
- Reset asserted mid-stream flushes both stages. The first word after reset release is checked against INIT_RD.

## Structure
- Package dec_8b10b_pkg holds:
  - Twelve K byte constants (K28_0..K28_7, K23_7, K27_7, K29_7, K30_7).
  - RD_MINUS/RD_PLUS constants.
  - Sub-block class enum: NEG, NEU, POS, NEU_FLIP_P (000111/0011), NEU_FLIP_N (111000/1100), ILLEGAL.
- Sub-module dec_6b5b: combinational abcdei → {EDCBA, class, legal}. It is instantiated once. The 4b lookup is small enough to stay inline in the top.

## Test plan
- Reset with INIT_RD = 0, send 0011111010 (K28.5 RD-) → two cycles later o_data = 0xBC, o_k = 1, no errors, o_rd = 1.
- Next cycle send 1100000101 (K28.5 RD+) → o_data = 0xBC, o_k = 1, o_rd = 0. Then send 1010101010 → o_data = 0xB5, o_k = 0, o_rd stays 0.
- With RD- send 1100000101 → o_data = 0xBC, o_k = 1, o_disp_err = 1, o_rd = 0. Send 0011111010 next → clean decode, o_rd = 1.
- Send 1111111111 and 0000011111 → o_code_err = 1, o_data = 0, o_k = 0, o_rd unchanged.
- Alternate i_valid 1/0 over 8 cycles of K28.5 → o_valid mirrors the pattern delayed by 2, and RD toggles only on valid words.
- Assert rst mid-stream, then i_rd_clr during a valid word → o_valid = 0 during reset, and the next word is checked against INIT_RD.

Source files
------------

// File: rtl/dec_8b10b_pkg.sv
// -----------------------------------------------------------------------------
// dec_8b10b_pkg
// Shared definitions for the 8b/10b receive decoder:
//   - running-disparity encodings (RD_MINUS / RD_PLUS)
//   - the twelve legal control-character byte values
//   - sub-block disparity class enum
//   - helpers for the per-sub-block disparity check and RD update
// -----------------------------------------------------------------------------
package dec_8b10b_pkg;

  localparam logic RD_MINUS = 1'b0;
  localparam logic RD_PLUS  = 1'b1;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // NEU_FLIP_P is 000111/0011, NEU_FLIP_N is 111000/1100: balanced, but they
  // force the running disparity like an unbalanced sub-block would.
  typedef enum logic [2:0] {
    NEG,
    NEU,
    POS,
    NEU_FLIP_P,
    NEU_FLIP_N,
    ILLEGAL
  } sb_class_e;

  // True when a sub-block of this class may not follow the given RD.
  function automatic logic disp_bad(input sb_class_e cls, input logic rd);
    case (cls)
      POS, NEU_FLIP_N: return rd == RD_PLUS;
      NEG, NEU_FLIP_P: return rd == RD_MINUS;
      default:         return 1'b0;
    endcase
  endfunction

  // RD after a sub-block; neutral and illegal sub-blocks leave it alone.
  function automatic logic rd_next(input sb_class_e cls, input logic rd);
    case (cls)
      POS, NEU_FLIP_P: return RD_PLUS;
      NEG, NEU_FLIP_N: return RD_MINUS;
      default:         return rd;
    endcase
  endfunction

  // Classify a 4b (fghj) sub-block. Every 1/2/3-ones pattern is in the table.
  function automatic sb_class_e class4(input logic [3:0] sb);
    logic [2:0] ones;
    ones = 3'($countones(sb));
    case (ones)
      3'd1:    return NEG;
      3'd3:    return POS;
      3'd2: begin
        if (sb == 4'b0011)      return NEU_FLIP_P;
        else if (sb == 4'b1100) return NEU_FLIP_N;
        else                    return NEU;
      end
      default: return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/dec_8b10b_if.sv
// -----------------------------------------------------------------------------
// dec_8b10b_if
// Code-group input and decoded-byte output bundle of the 8b/10b decoder.
//   i_data[9:0]  code group abcdeifghj (a = bit 9)
//   i_valid      i_data qualifies this cycle
//   i_rd_clr     force running disparity back to its initial value
//   o_data[7:0]  decoded byte HGFEDCBA
//   o_k          control character flag
//   o_valid      outputs qualify this cycle
//   o_code_err   code group not in the table
//   o_disp_err   code group legal but wrong for the running disparity
//   o_rd         running disparity after the last decoded group
// master: the code-group source / byte sink. slave: the decoder.
// -----------------------------------------------------------------------------
interface dec_8b10b_if;
  logic [9:0] i_data;
  logic       i_valid;
  logic       i_rd_clr;
  logic [7:0] o_data;
  logic       o_k;
  logic       o_valid;
  logic       o_code_err;
  logic       o_disp_err;
  logic       o_rd;

  modport master (
    output i_data, i_valid, i_rd_clr,
    input  o_data, o_k, o_valid, o_code_err, o_disp_err, o_rd
  );

  modport slave (
    input  i_data, i_valid, i_rd_clr,
    output o_data, o_k, o_valid, o_code_err, o_disp_err, o_rd
  );
endinterface

// File: rtl/dec_8b10b_6b5b.sv
// -----------------------------------------------------------------------------
// dec_6b5b
// Combinational 6b -> 5b lookup for the 8b/10b decoder.
//   sb6[5:0]   sub-block abcdei (a = bit 5)
//   dat5[4:0]  decoded EDCBA (0 when illegal)
//   cls        disparity class of the sub-block (ILLEGAL when not in table)
//   legal      sub-block is one of the table entries (D0..D31 or K28)
// -----------------------------------------------------------------------------
module dec_6b5b
  import dec_8b10b_pkg::*;
(
  input  logic [5:0] sb6,
  output logic [4:0] dat5,
  output sb_class_e  cls,
  output logic       legal
);

  logic [2:0] ones;

  always_comb begin
    dat5  = 5'd0;
    legal = 1'b1;
    case (sb6)
      6'b100111, 6'b011000: dat5 = 5'd0;
      6'b011101, 6'b100010: dat5 = 5'd1;
      6'b101101, 6'b010010: dat5 = 5'd2;
      6'b110001:            dat5 = 5'd3;
      6'b110101, 6'b001010: dat5 = 5'd4;
      6'b101001:            dat5 = 5'd5;
      6'b011001:            dat5 = 5'd6;
      6'b111000, 6'b000111: dat5 = 5'd7;
      6'b111001, 6'b000110: dat5 = 5'd8;
      6'b100101:            dat5 = 5'd9;
      6'b010101:            dat5 = 5'd10;
      6'b110100:            dat5 = 5'd11;
      6'b001101:            dat5 = 5'd12;
      6'b101100:            dat5 = 5'd13;
      6'b011100:            dat5 = 5'd14;
      6'b010111, 6'b101000: dat5 = 5'd15;
      6'b011011, 6'b100100: dat5 = 5'd16;
      6'b100011:            dat5 = 5'd17;
      6'b010011:            dat5 = 5'd18;
      6'b110010:            dat5 = 5'd19;
      6'b001011:            dat5 = 5'd20;
      6'b101010:            dat5 = 5'd21;
      6'b011010:            dat5 = 5'd22;
      6'b111010, 6'b000101: dat5 = 5'd23;
      6'b110011, 6'b001100: dat5 = 5'd24;
      6'b100110:            dat5 = 5'd25;
      6'b010110:            dat5 = 5'd26;
      6'b110110, 6'b001001: dat5 = 5'd27;
      6'b001110:            dat5 = 5'd28;
      6'b101110, 6'b010001: dat5 = 5'd29;
      6'b011110, 6'b100001: dat5 = 5'd30;
      6'b101011, 6'b010100: dat5 = 5'd31;
      6'b001111, 6'b110000: dat5 = 5'd28;
      default:              legal = 1'b0;
    endcase

    ones = 3'($countones(sb6));
    cls  = ILLEGAL;
    if (legal) begin
      case (ones)
        3'd2:    cls = NEG;
        3'd4:    cls = POS;
        3'd3: begin
          if (sb6 == 6'b000111)      cls = NEU_FLIP_P;
          else if (sb6 == 6'b111000) cls = NEU_FLIP_N;
          else                       cls = NEU;
        end
        default: cls = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/dec_8b10b.sv
// -----------------------------------------------------------------------------
// dec_8b10b
// Receive-side 8b/10b decoder. Two-stage pipeline: stage 1 registers the code
// group, stage 2 decodes it, checks it against the running disparity and
// registers the result. One group per cycle, latency two cycles.
//   clk      core clock, rising edge
//   rst      asynchronous active-high reset
//   bus      dec_8b10b_if.slave (code group in, decoded byte and flags out)
// Parameter INIT_RD: running disparity after reset and on i_rd_clr.
// -----------------------------------------------------------------------------
module dec_8b10b
  import dec_8b10b_pkg::*;
#(
  parameter logic INIT_RD = RD_MINUS
)
(
  input  logic         clk,
  input  logic         rst,
  dec_8b10b_if.slave   bus
);

  logic [9:0] data_p1;
  logic       vld_p1;

  logic [7:0] data_p2;
  logic       k_p2;
  logic       vld_p2;
  logic       code_err_p2;
  logic       disp_err_p2;
  logic       rd_p2;

  logic [5:0] sb6;
  logic [3:0] sb4;
  logic [3:0] sb4_lk;
  logic [4:0] dat5;
  logic [2:0] dat3;
  logic       legal6;
  sb_class_e  cls6;
  sb_class_e  cls4;
  logic [7:0] byte_dec;
  logic       k28;
  logic       a7;
  logic       p7;
  logic       kx7;
  logic       a7_ok;
  logic       is_k;
  logic       code_err;
  logic       disp_err;
  logic       bad6;
  logic       bad4;
  logic       rd_mid;
  logic       rd_out;

  // ---- stage 1: register the code group ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= bus.i_valid;
  end

  always_ff @(posedge clk) begin
    data_p1 <= bus.i_data;
  end

  // ---- stage 2: decode, classify, disparity check ----
  assign sb6 = data_p1[9:4];
  assign sb4 = data_p1[3:0];

  dec_6b5b u_6b5b (
    .sb6   (sb6),
    .dat5  (dat5),
    .cls   (cls6),
    .legal (legal6)
  );

  always_comb begin
    k28 = (sb6 == 6'b001111) || (sb6 == 6'b110000);
    // After 110000 the balanced K28 4b codes are sent inverted relative to
    // the data table; complementing restores the y value for every K28.y.
    sb4_lk = (sb6 == 6'b110000) ? ~sb4 : sb4;

    dat3 = 3'd0;
    case (sb4_lk)
      4'b1011, 4'b0100:                   dat3 = 3'd0;
      4'b1001:                            dat3 = 3'd1;
      4'b0101:                            dat3 = 3'd2;
      4'b1100, 4'b0011:                   dat3 = 3'd3;
      4'b1101, 4'b0010:                   dat3 = 3'd4;
      4'b1010:                            dat3 = 3'd5;
      4'b0110:                            dat3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dat3 = 3'd7;
      default:                            dat3 = 3'd0;
    endcase
    cls4 = class4(sb4);

    a7 = (sb4 == 4'b0111) || (sb4 == 4'b1000);
    p7 = (sb4 == 4'b1110) || (sb4 == 4'b0001);
    byte_dec = {dat3, dat5};

    kx7 = a7 && (byte_dec inside {K23_7, K27_7, K29_7, K30_7});
    // Data A7 only where P7 would create a run of five: x=17/18/20 in the
    // RD- column (0111), x=11/13/14 in the RD+ column (1000).
    a7_ok = ((sb4 == 4'b0111) && (dat5 inside {5'd17, 5'd18, 5'd20})) ||
            ((sb4 == 4'b1000) && (dat5 inside {5'd11, 5'd13, 5'd14}));
    is_k  = (k28 && !p7) || kx7;

    code_err = !legal6 || (cls4 == ILLEGAL) || (k28 && p7) ||
               (a7 && !k28 && !kx7 && !a7_ok);

    bad6   = disp_bad(cls6, rd_p2);
    rd_mid = rd_next(cls6, rd_p2);
    bad4   = disp_bad(cls4, rd_mid);
    rd_out = rd_next(cls4, rd_mid);

    disp_err = !code_err && (bad6 || bad4);
  end

  // The RD update is kept even for code/disparity errors so the receiver
  // follows the line; a same-cycle clear overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p2     <= 8'h00;
      k_p2        <= 1'b0;
      vld_p2      <= 1'b0;
      code_err_p2 <= 1'b0;
      disp_err_p2 <= 1'b0;
      rd_p2       <= INIT_RD;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2     <= code_err ? 8'h00 : byte_dec;
        k_p2        <= !code_err && is_k;
        code_err_p2 <= code_err;
        disp_err_p2 <= disp_err;
      end
      if (bus.i_rd_clr)  rd_p2 <= INIT_RD;
      else if (vld_p1)   rd_p2 <= rd_out;
    end
  end

  assign bus.o_data     = data_p2;
  assign bus.o_k        = k_p2;
  assign bus.o_valid    = vld_p2;
  assign bus.o_code_err = code_err_p2;
  assign bus.o_disp_err = disp_err_p2;
  assign bus.o_rd       = rd_p2;

endmodule
